fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of PC, instruction and counter datapaths.
REQ-002 Parameter PC_RESET, default 32'h0000_0000, PC value loaded on reset.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit hold request; freezes PC and IF/ID.
REQ-006 flush  input  1  taken branch/jump resolved in EX; redirect fetch.
REQ-007 br_target  input  DATA_W  redirect address, valid when flush=1.
REQ-008 imem_addr  output  DATA_W  instruction memory address, equal to current PC (combinational).
REQ-009 imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-010 if_id_pc  output  DATA_W  PC of instruction held in IF/ID.
REQ-011 if_id_pc4  output  DATA_W  if_id_pc + 4.
REQ-012 if_id_instr  output  32  instruction held in IF/ID.
REQ-013 if_id_valid  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-014 fetch_cnt  output  DATA_W  count of instructions captured into IF/ID.
REQ-015 stall_cnt  output  DATA_W  count of cycles with stall=1 and flush=0.

Function
REQ-016 PC register SHALL update each cycle by priority: reset > flush > stall > sequential.
REQ-017 flush=1: PC SHALL load {br_target[DATA_W-1:2], 2'b00}; low two bits always forced to zero.
REQ-018 stall=1, flush=0: PC SHALL hold.
REQ-019 Otherwise PC SHALL load PC+4, modulo 2^DATA_W (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-020 IF/ID SHALL update with same priority: flush -> bubble; stall -> hold all fields; else capture PC, PC+4, imem_rdata, valid=1.
REQ-021 Bubble SHALL be if_id_instr=NOP (32'h0000_0013), if_id_valid=0, if_id_pc=0, if_id_pc4=0.
REQ-022 flush and stall both high SHALL behave as flush only (flush wins, stall ignored that cycle).
REQ-023 Fetch-to-IF/ID latency SHALL be exactly one cycle; instruction at address A appears in IF/ID the cycle after PC=A with no stall/flush.
REQ-024 First instruction after a flush SHALL appear in IF/ID two cycles after flush asserted (one bubble cycle).
REQ-025 fetch_cnt SHALL increment by 1 on every IF/ID capture (REQ-020 third case), wrapping at 2^DATA_W.
REQ-026 stall_cnt SHALL increment by 1 on every cycle with stall=1, flush=0, wrapping at 2^DATA_W.
REQ-027 imem_addr SHALL never carry nonzero bits [1:0].

Reset
REQ-028 On reset=1 at a rising edge: PC=PC_RESET, IF/ID=bubble per REQ-021, fetch_cnt=0, stall_cnt=0.
REQ-029 reset SHALL override stall and flush in the same cycle.
REQ-030 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state; first capture occurs on the first edge after reset deasserts.
REQ-031 Reset-held outputs: imem_addr=PC_RESET, if_id_valid=0, if_id_instr=NOP.

Structure
REQ-032 Shared package riscv_pkg SHALL hold DATA_W default, NOP encoding 32'h0000_0013, and PC_RESET default.
REQ-033 PC register and its next-PC mux SHALL be a sub-module pc_counter (inputs clk, reset, stall, flush, br_target; output pc).
REQ-034 IF/ID register and counters SHALL reside in fetch_stage top; no other sub-modules.

Verification
REQ-035 Reset release, no stall/flush, imem returns addr-based words -> IF/ID pc sequence 0,4,8,12, valid=1 from second cycle, fetch_cnt=3 after 4 cycles.
REQ-036 stall=1 for 3 cycles at PC=0x10 -> PC and IF/ID frozen (if_id_pc=0x0C), stall_cnt=3, fetch_cnt unchanged.
REQ-037 flush=1 with br_target=0x0000_0103 -> next PC=0x100, IF/ID bubble (NOP, valid=0) one cycle, then if_id_pc=0x100 valid=1.
REQ-038 flush=1 and stall=1 same cycle, br_target=0x40 -> PC=0x40, bubble inserted, stall_cnt not incremented.
REQ-039 PC_RESET=0xFFFF_FFF8, run 3 cycles -> PC sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; if_id_pc4 of 0xFFFF_FFFC equals 0.
REQ-040 reset asserted during stall with fetch_cnt=5 -> next edge PC=PC_RESET, valid=0, both counters 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V front-end constants for the fetch stage
package riscv_pkg;
  localparam int          DATA_W_DEF   = 32;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013; // addi x0, x0, 0

  typedef enum logic [1:0] {
    PC_SEL_SEQ   = 2'd0,
    PC_SEL_HOLD  = 2'd1,
    PC_SEL_REDIR = 2'd2
  } pc_sel_e;
endpackage

// File: rtl/fetch_stage_pc_counter.sv
// rtl/fetch_stage_pc_counter.sv - PC register with flush > stall > sequential next-PC mux
module pc_counter
  import riscv_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(PC_RESET_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] br_target,
  output logic [DATA_W-1:0] pc
);

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_d;
  pc_sel_e           sel;

  always_comb begin
    sel = PC_SEL_SEQ;
    if (flush)      sel = PC_SEL_REDIR;
    else if (stall) sel = PC_SEL_HOLD;
  end

  // Redirect targets are word-aligned here so imem_addr can never be misaligned.
  always_comb begin
    pc_d = pc_q + DATA_W'(4);
    case (sel)
      PC_SEL_REDIR: pc_d = {br_target[DATA_W-1:2], 2'b00};
      PC_SEL_HOLD:  pc_d = pc_q;
      default:      pc_d = pc_q + DATA_W'(4);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= {PC_RESET[DATA_W-1:2], 2'b00};
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, IF/ID pipeline register, fetch and stall counters
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(PC_RESET_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] br_target,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [DATA_W-1:0] if_id_pc,
  output logic [DATA_W-1:0] if_id_pc4,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] fetch_cnt,
  output logic [DATA_W-1:0] stall_cnt
);

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_q,    pc_d;
  logic [DATA_W-1:0] pc4_q,   pc4_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] fcnt_q,  fcnt_d;
  logic [DATA_W-1:0] scnt_q,  scnt_d;

  pc_counter #(
    .DATA_W   (DATA_W),
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .br_target (br_target),
    .pc        (pc)
  );

  // Flush beats stall: a redirect always bubbles and never counts as a stall cycle.
  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fcnt_d  = fcnt_q;
    scnt_d  = scnt_q;
    if (flush) begin
      pc_d    = '0;
      pc4_d   = '0;
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (stall) begin
      scnt_d  = scnt_q + DATA_W'(1);
    end else begin
      pc_d    = pc;
      pc4_d   = pc + DATA_W'(4);
      instr_d = imem_rdata;
      valid_d = 1'b1;
      fcnt_d  = fcnt_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
      fcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign imem_addr   = pc;
  assign if_id_pc    = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;
  assign fetch_cnt   = fcnt_q;
  assign stall_cnt   = scnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] br_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr, fetch_cnt, stall_cnt;
  logic        if_id_valid;

  logic        reset_w;
  logic        stall_w = 1'b0;
  logic        flush_w = 1'b0;
  logic [31:0] br_target_w = 32'h0;
  logic [31:0] imem_addr_w, imem_rdata_w;
  logic [31:0] if_id_pc_w, if_id_pc4_w, if_id_instr_w, fetch_cnt_w, stall_cnt_w;
  logic        if_id_valid_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word derived from its address.
  assign imem_rdata   = imem_addr   ^ 32'hA5A5_0000;
  assign imem_rdata_w = imem_addr_w ^ 32'hA5A5_0000;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .br_target(br_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  fetch_stage #(.DATA_W(32), .PC_RESET(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset_w), .stall(stall_w), .flush(flush_w), .br_target(br_target_w),
    .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w), .if_id_pc(if_id_pc_w),
    .if_id_pc4(if_id_pc4_w), .if_id_instr(if_id_instr_w), .if_id_valid(if_id_valid_w),
    .fetch_cnt(fetch_cnt_w), .stall_cnt(stall_cnt_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; flush = 1'b1; br_target = 32'h0000_0055;
    step(); step();
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_imem_addr got %h want %h", imem_addr, 32'h0); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
    n_cmp++; if (if_id_instr !== NOP_W) begin n_err++; $display("FAIL reset_instr got %h want %h", if_id_instr, NOP_W); end
    n_cmp++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h/%h want 0/0", if_id_pc, if_id_pc4); end
    n_cmp++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", fetch_cnt, stall_cnt); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] exp_in [4] = '{32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008, 32'hA5A5_000C};
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    n_cmp++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin n_err++; $display("FAIL seq_first got addr %h valid %b want 0/0", imem_addr, if_id_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (if_id_pc !== exp_pc[k] || if_id_valid !== 1'b1) begin n_err++; $display("FAIL seq_pc[%0d] got %h v%b want %h v1", k, if_id_pc, if_id_valid, exp_pc[k]); end
      n_cmp++; if (if_id_instr !== exp_in[k]) begin n_err++; $display("FAIL seq_instr[%0d] got %h want %h", k, if_id_instr, exp_in[k]); end
      n_cmp++; if (if_id_pc4 !== exp_pc[k] + 32'h4) begin n_err++; $display("FAIL seq_pc4[%0d] got %h want %h", k, if_id_pc4, exp_pc[k] + 32'h4); end
      n_cmp++; if (imem_addr !== exp_pc[k] + 32'h4) begin n_err++; $display("FAIL seq_addr[%0d] got %h want %h", k, imem_addr, exp_pc[k] + 32'h4); end
      n_cmp++; if (fetch_cnt !== 32'(k + 1)) begin n_err++; $display("FAIL seq_fetch_cnt[%0d] got %0d want %0d", k, fetch_cnt, k + 1); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL stall_addr[%0d] got %h want 10", k, imem_addr); end
      n_cmp++; if (if_id_pc !== 32'hC || if_id_instr !== 32'hA5A5_000C || if_id_valid !== 1'b1) begin n_err++; $display("FAIL stall_ifid[%0d] got %h %h v%b want c a5a5000c v1", k, if_id_pc, if_id_instr, if_id_valid); end
      n_cmp++; if (stall_cnt !== 32'(k) || fetch_cnt !== 32'd4) begin n_err++; $display("FAIL stall_cnt[%0d] got s%0d f%0d want s%0d f4", k, stall_cnt, fetch_cnt, k); end
    end
    stall = 1'b0;
  endtask

  task automatic test_flush();
    flush = 1'b1; br_target = 32'h0000_0103;
    step();
    flush = 1'b0;
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL flush_addr got %h want 100", imem_addr); end
    n_cmp++; if (if_id_instr !== NOP_W || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin n_err++; $display("FAIL flush_bubble got %h v%b %h/%h want 13 v0 0/0", if_id_instr, if_id_valid, if_id_pc, if_id_pc4); end
    n_cmp++; if (fetch_cnt !== 32'd4 || stall_cnt !== 32'd3) begin n_err++; $display("FAIL flush_cnt got f%0d s%0d want f4 s3", fetch_cnt, stall_cnt); end
    step();
    n_cmp++; if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1 || if_id_instr !== 32'hA5A5_0100) begin n_err++; $display("FAIL flush_target got %h v%b %h want 100 v1 a5a50100", if_id_pc, if_id_valid, if_id_instr); end
    n_cmp++; if (imem_addr !== 32'h104 || fetch_cnt !== 32'd5) begin n_err++; $display("FAIL flush_after got %h f%0d want 104 f5", imem_addr, fetch_cnt); end
  endtask

  task automatic test_flush_stall();
    flush = 1'b1; stall = 1'b1; br_target = 32'h0000_0040;
    step();
    flush = 1'b0;
    n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL fs_addr got %h want 40", imem_addr); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP_W) begin n_err++; $display("FAIL fs_bubble got v%b %h want v0 13", if_id_valid, if_id_instr); end
    n_cmp++; if (stall_cnt !== 32'd3 || fetch_cnt !== 32'd5) begin n_err++; $display("FAIL fs_cnt got s%0d f%0d want s3 f5", stall_cnt, fetch_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    step();
    n_cmp++; if (imem_addr !== 32'h40 || stall_cnt !== 32'd4 || fetch_cnt !== 32'd5) begin n_err++; $display("FAIL rms_pre got %h s%0d f%0d want 40 s4 f5", imem_addr, stall_cnt, fetch_cnt); end
    reset = 1'b1;
    step();
    n_cmp++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin n_err++; $display("FAIL rms_reset got %h v%b want 0 v0", imem_addr, if_id_valid); end
    n_cmp++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin n_err++; $display("FAIL rms_cnt got f%0d s%0d want 0/0", fetch_cnt, stall_cnt); end
    reset = 1'b0; stall = 1'b0;
    step();
    n_cmp++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || fetch_cnt !== 32'd1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL rms_first got %h v%b f%0d a%h want 0 v1 f1 a4", if_id_pc, if_id_valid, fetch_cnt, imem_addr); end
  endtask

  task automatic test_wrap();
    n_cmp++; if (imem_addr_w !== 32'hFFFF_FFF8 || if_id_valid_w !== 1'b0) begin n_err++; $display("FAIL wrap_reset got %h v%b want fffffff8 v0", imem_addr_w, if_id_valid_w); end
    reset_w = 1'b0;
    step();
    n_cmp++; if (imem_addr_w !== 32'hFFFF_FFFC || if_id_pc_w !== 32'hFFFF_FFF8 || if_id_instr_w !== 32'h5A5A_FFF8) begin n_err++; $display("FAIL wrap_c1 got %h %h %h want fffffffc fffffff8 5a5afff8", imem_addr_w, if_id_pc_w, if_id_instr_w); end
    step();
    n_cmp++; if (imem_addr_w !== 32'h0 || if_id_pc_w !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_c2 got %h %h want 0 fffffffc", imem_addr_w, if_id_pc_w); end
    n_cmp++; if (if_id_pc4_w !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h want 0", if_id_pc4_w); end
    step();
    n_cmp++; if (imem_addr_w !== 32'h4 || if_id_pc_w !== 32'h0 || fetch_cnt_w !== 32'd3) begin n_err++; $display("FAIL wrap_c3 got %h %h f%0d want 4 0 f3", imem_addr_w, if_id_pc_w, fetch_cnt_w); end
  endtask

  initial begin
    reset_w = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_flush_stall();
    test_reset_mid_stall();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
